mem_dump_arbiter: RTL and testbench

MEM_DUMP_ARBITER -- requirements
Module: mem_dump_arbiter

---
 rtl/mem_dump_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_dump_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_arbiter.sv
// Arbitrates data memory between the CPU MEM stage and a debug dump engine.
// The dump walks all of data memory word by word and streams it out with valid/ready.
module mem_dump_arbiter #(
    parameter int NB_WIDTH = 32,
    parameter int NB_ADDR  = 9,
    parameter int NB_BHW   = 3
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NB_WIDTH-1:0] i_cpu_addr,
    input  logic [NB_WIDTH-1:0] i_cpu_data,
    input  logic                i_cpu_read,
    input  logic                i_cpu_write,
    input  logic [NB_BHW-1:0]   i_cpu_bhw,
    output logic [NB_WIDTH-1:0] o_cpu_rdata,
    output logic                o_cpu_stall,
    input  logic                i_dump_start,
    input  logic                i_dump_ready,
    output logic                o_dump_valid,
    output logic [NB_WIDTH-1:0] o_dump_data,
    output logic [NB_ADDR-1:0]  o_dump_addr,
    output logic                o_dump_busy,
    output logic                o_dump_done,
    output logic [NB_WIDTH-1:0] o_mem_addr,
    output logic [NB_WIDTH-1:0] o_mem_data,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic [NB_BHW-1:0]   o_mem_bhw,
    input  logic [NB_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    localparam logic [NB_ADDR-1:0] LAST_ADDR = {{(NB_ADDR-2){1'b1}}, 2'b00};
    localparam logic [NB_ADDR-1:0] STEP      = NB_ADDR'(4);
    localparam logic [NB_BHW-1:0]  BHW_WORD  = NB_BHW'(3);

    state_t               state_q, state_d;
    logic [NB_ADDR-1:0]   cnt_q, cnt_d;
    logic [NB_ADDR-1:0]   addr_q, addr_d;
    logic [NB_WIDTH-1:0]  data_q, data_d;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Read data is only meaningful to the CPU in IDLE; it is stalled otherwise.
    assign o_cpu_rdata = i_mem_rdata;
    assign o_dump_data = data_q;
    assign o_dump_addr = addr_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        o_mem_addr   = '0;
        o_mem_data   = '0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_mem_bhw    = '0;
        o_cpu_stall  = 1'b1;
        o_dump_valid = 1'b0;
        o_dump_busy  = 1'b1;
        o_dump_done  = 1'b0;

        case (state_q)
            IDLE: begin
                // The CPU access of the start cycle still completes.
                o_mem_addr  = i_cpu_addr;
                o_mem_data  = i_cpu_data;
                o_mem_read  = i_cpu_read;
                o_mem_write = i_cpu_write;
                o_mem_bhw   = i_cpu_bhw;
                o_cpu_stall = 1'b0;
                o_dump_busy = 1'b0;
                if (i_dump_start) begin
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                o_mem_addr = NB_WIDTH'(cnt_q);
                o_mem_read = 1'b1;
                o_mem_bhw  = BHW_WORD;
                state_d    = CAPTURE;
            end
            CAPTURE: begin
                data_d  = i_mem_rdata;
                addr_d  = cnt_q;
                state_d = SEND;
            end
            SEND: begin
                o_dump_valid = 1'b1;
                if (i_dump_ready) begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + STEP;
                        state_d = REQ;
                    end
                end
            end
            DONE: begin
                o_dump_done = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_dump_arbiter.sv
// Directed bench for mem_dump_arbiter with a byte-addressed, one-cycle-latency memory model.
module tb_mem_dump_arbiter;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_cpu_addr, i_cpu_data;
    logic        i_cpu_read, i_cpu_write;
    logic [2:0]  i_cpu_bhw;
    logic [31:0] o_cpu_rdata;
    logic        o_cpu_stall;
    logic        i_dump_start, i_dump_ready;
    logic        o_dump_valid;
    logic [31:0] o_dump_data;
    logic [8:0]  o_dump_addr;
    logic        o_dump_busy, o_dump_done;
    logic [31:0] o_mem_addr, o_mem_data;
    logic        o_mem_read, o_mem_write;
    logic [2:0]  o_mem_bhw;
    logic [31:0] mem_rdata_q;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_word [0:127];

    always #5 clk = ~clk;

    mem_dump_arbiter dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_cpu_addr   (i_cpu_addr),
        .i_cpu_data   (i_cpu_data),
        .i_cpu_read   (i_cpu_read),
        .i_cpu_write  (i_cpu_write),
        .i_cpu_bhw    (i_cpu_bhw),
        .o_cpu_rdata  (o_cpu_rdata),
        .o_cpu_stall  (o_cpu_stall),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .o_dump_valid (o_dump_valid),
        .o_dump_data  (o_dump_data),
        .o_dump_addr  (o_dump_addr),
        .o_dump_busy  (o_dump_busy),
        .o_dump_done  (o_dump_done),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .o_mem_read   (o_mem_read),
        .o_mem_write  (o_mem_write),
        .o_mem_bhw    (o_mem_bhw),
        .i_mem_rdata  (mem_rdata_q)
    );

    // Little-endian byte memory: size code 000 is a byte store, anything else a word store.
    logic [7:0] mem [0:511];
    logic [8:0] ma;
    assign ma = o_mem_addr[8:0];

    always @(posedge clk) begin
        if (o_mem_write) begin
            if (o_mem_bhw[1:0] == 2'b00) begin
                mem[ma] <= o_mem_data[7:0];
            end else begin
                mem[{ma[8:2], 2'b00}] <= o_mem_data[7:0];
                mem[{ma[8:2], 2'b01}] <= o_mem_data[15:8];
                mem[{ma[8:2], 2'b10}] <= o_mem_data[23:16];
                mem[{ma[8:2], 2'b11}] <= o_mem_data[31:24];
            end
        end
        if (o_mem_read)
            mem_rdata_q <= {mem[{ma[8:2], 2'b11}], mem[{ma[8:2], 2'b10}],
                            mem[{ma[8:2], 2'b01}], mem[{ma[8:2], 2'b00}]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dump_run(input int hold_addr, input int lock_cyc, input int abort_words,
                            input bit with_sb);
        int  idx;
        int  hold_left;
        int  dones;
        int  done_cyc;
        bit  held;
        bit  finished;
        idx = 0; hold_left = 0; dones = 0; done_cyc = -1; held = 0; finished = 0;
        i_dump_ready = 1'b1;
        if (with_sb) begin
            i_cpu_addr  = 32'h0000_0011;
            i_cpu_data  = 32'h0000_00AB;
            i_cpu_bhw   = 3'b000;
            i_cpu_write = 1'b1;
        end
        i_dump_start = 1'b1;
        #1;
        check("start_cycle_stall", 32'(o_cpu_stall), 32'd0);
        if (with_sb) check("start_cycle_write", 32'(o_mem_write), 32'd1);
        tick();
        i_dump_start = 1'b0;
        i_cpu_write  = 1'b0;
        #1;
        check("req_busy", 32'(o_dump_busy), 32'd1);
        check("req_stall", 32'(o_cpu_stall), 32'd1);
        check("req_read", 32'(o_mem_read), 32'd1);
        check("req_addr", o_mem_addr, 32'd0);
        check("req_bhw", 32'(o_mem_bhw), 32'd3);
        for (int cyc = 1; cyc <= 600; cyc++) begin
            tick();
            i_cpu_write  = 1'b0;
            i_dump_start = 1'b0;
            if (abort_words > 0 && idx == abort_words) begin
                check("abort_busy_before", 32'(o_dump_busy), 32'd1);
                i_cpu_addr = 32'h0000_0044;
                i_cpu_read = 1'b0;
                i_reset    = 1'b0;
                #1;
                check("abort_valid", 32'(o_dump_valid), 32'd0);
                check("abort_busy", 32'(o_dump_busy), 32'd0);
                check("abort_done", 32'(o_dump_done), 32'd0);
                check("abort_daddr", 32'(o_dump_addr), 32'd0);
                check("abort_ddata", o_dump_data, 32'd0);
                check("abort_stall", 32'(o_cpu_stall), 32'd0);
                check("abort_passaddr", o_mem_addr, 32'h0000_0044);
                tick();
                tick();
                i_reset = 1'b1;
                for (int k = 0; k < 20; k++) begin
                    tick();
                    check("post_abort_quiet",
                          {29'd0, o_dump_valid, o_dump_done, o_dump_busy}, 32'd0);
                end
                return;
            end
            if (hold_left > 0) begin
                check("hold_valid", 32'(o_dump_valid), 32'd1);
                check("hold_addr", 32'(o_dump_addr), 32'(hold_addr));
                check("hold_data", o_dump_data, exp_word[idx]);
                check("hold_no_read", 32'(o_mem_read), 32'd0);
                hold_left--;
                if (hold_left == 0) begin
                    i_dump_ready = 1'b1;
                    idx++;
                end
            end else if (o_dump_valid) begin
                check("dump_addr", 32'(o_dump_addr), 32'(idx * 4));
                check("dump_data", o_dump_data, (idx < 128) ? exp_word[idx] : 32'hFFFF_FFFF);
                if (int'(o_dump_addr) == hold_addr && !held) begin
                    held         = 1'b1;
                    hold_left    = 10;
                    i_dump_ready = 1'b0;
                end else begin
                    idx++;
                end
            end
            if (o_dump_done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == lock_cyc) begin
                i_cpu_addr   = 32'h0000_0020;
                i_cpu_data   = 32'hDEAD_BEEF;
                i_cpu_bhw    = 3'b011;
                i_cpu_write  = 1'b1;
                i_dump_start = 1'b1;
                #1;
                check("lock_stall", 32'(o_cpu_stall), 32'd1);
                check("lock_write", 32'(o_mem_write), 32'd0);
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check("done_cycle", 32'(done_cyc), (hold_addr >= 0) ? 32'd394 : 32'd384);
                check("done_pulses", 32'(dones), 32'd1);
                check("word_count", 32'(idx), 32'd128);
                check("busy_after_done", 32'(o_dump_busy), 32'd0);
                check("stall_after_done", 32'(o_cpu_stall), 32'd0);
                finished = 1'b1;
                break;
            end
        end
        if (!finished) check("dump_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset      = 1'b0;
        i_cpu_addr   = 32'h0000_01A4;
        i_cpu_data   = 32'h0000_0055;
        i_cpu_read   = 1'b1;
        i_cpu_write  = 1'b0;
        i_cpu_bhw    = 3'b010;
        i_dump_start = 1'b0;
        i_dump_ready = 1'b0;
        #1;
        check("rst_valid", 32'(o_dump_valid), 32'd0);
        check("rst_busy", 32'(o_dump_busy), 32'd0);
        check("rst_done", 32'(o_dump_done), 32'd0);
        check("rst_daddr", 32'(o_dump_addr), 32'd0);
        check("rst_ddata", o_dump_data, 32'd0);
        check("rst_stall", 32'(o_cpu_stall), 32'd0);
        check("rst_pass_addr", o_mem_addr, 32'h0000_01A4);
        check("rst_pass_data", o_mem_data, 32'h0000_0055);
        check("rst_pass_read", 32'(o_mem_read), 32'd1);
        check("rst_pass_bhw", 32'(o_mem_bhw), 32'd2);
        tick();
        i_cpu_read = 1'b0;
        tick();
        i_reset = 1'b1;
        tick();

        // CPU store then load through the IDLE pass-through path
        i_cpu_addr  = 32'h0000_0010;
        i_cpu_data  = 32'h1234_5678;
        i_cpu_bhw   = 3'b011;
        i_cpu_write = 1'b1;
        #1;
        check("sw_write", 32'(o_mem_write), 32'd1);
        check("sw_stall", 32'(o_cpu_stall), 32'd0);
        check("sw_addr", o_mem_addr, 32'h0000_0010);
        tick();
        i_cpu_write = 1'b0;
        i_cpu_read  = 1'b1;
        #1;
        check("lw_read", 32'(o_mem_read), 32'd1);
        check("lw_stall", 32'(o_cpu_stall), 32'd0);
        tick();
        i_cpu_read = 1'b0;
        check("lw_rdata", o_cpu_rdata, 32'h1234_5678);
        check("lw_stall2", 32'(o_cpu_stall), 32'd0);

        // Preload word[i] = i through the CPU port
        for (int i = 0; i < 128; i++) begin
            i_cpu_addr  = 32'(i * 4);
            i_cpu_data  = 32'(i);
            i_cpu_bhw   = 3'b011;
            i_cpu_write = 1'b1;
            tick();
        end
        i_cpu_write = 1'b0;
        i_cpu_addr  = 32'd0;
        for (int i = 0; i < 128; i++) exp_word[i] = 32'(i);
        tick();

        // Full dump with the sink always ready
        dump_run(-1, -1, 0, 1'b0);
        tick();

        // Byte store coincident with start, backpressure on 0x004, lockout mid-dump
        exp_word[4] = 32'h0000_AB04;
        dump_run(4, 50, 0, 1'b1);
        check("sb_landed", 32'(mem[9'h011]), 32'h0000_00AB);
        check("lock_mem_unchanged",
              {mem[9'h023], mem[9'h022], mem[9'h021], mem[9'h020]}, 32'd8);
        tick();

        // Reset mid-dump after five words, then pass-through is back
        dump_run(-1, -1, 5, 1'b0);
        i_cpu_addr = 32'h0000_0010;
        i_cpu_read = 1'b1;
        #1;
        check("post_abort_read", 32'(o_mem_read), 32'd1);
        check("post_abort_stall", 32'(o_cpu_stall), 32'd0);
        tick();
        i_cpu_read = 1'b0;
        check("post_abort_rdata", o_cpu_rdata, 32'h0000_AB04);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
